// File: rtl/clock_display_pkg.sv
// Shared constants, BCD pair payload and segment encoder for the MM.SS display driver.
package clock_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    // Active-low segment codes, seg[0]=a .. seg[6]=g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [AN_W-1:0] AN_OFF  = 4'hF;
    localparam logic [AN_W-1:0] AN_DIG0 = 4'hE;
    localparam logic [AN_W-1:0] AN_DIG1 = 4'hD;
    localparam logic [AN_W-1:0] AN_DIG2 = 4'hB;
    localparam logic [AN_W-1:0] AN_DIG3 = 4'h7;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       valid;
    } bcd_pair_t;

    // An invalid pair, or any non-decimal digit, renders as a dash
    function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d, input logic valid);
        if (!valid) return SEG_DASH;
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational binary (0..59) to two-digit BCD; values above 59 flag invalid.
module bin2bcd_60 (
    input  logic [6:0] v,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    always_comb begin
        tens  = 4'd0;
        ones  = 4'd0;
        valid = (v <= 7'd59);
        if (valid) begin
            if      (v >= 7'd50) tens = 4'd5;
            else if (v >= 7'd40) tens = 4'd4;
            else if (v >= 7'd30) tens = 4'd3;
            else if (v >= 7'd20) tens = 4'd2;
            else if (v >= 7'd10) tens = 4'd1;
            ones = 4'(v - 7'(tens) * 7'd10);
        end
    end

endmodule

// File: rtl/mmss_sevenseg_driver.sv
// Multiplexed 4-digit MM.SS seven-segment driver with per-frame snapshot of the time.
module mmss_sevenseg_driver
    import clock_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] minute,
    input  logic [6:0] second,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0] prescaler;
    logic [IDX_W-1:0] digit_idx;
    logic             tick;
    logic             tick_d;
    bcd_pair_t        min_bcd, sec_bcd;
    bcd_pair_t        snap_min, snap_sec;
    logic [AN_W-1:0]  an_nxt;
    logic [SEG_W-1:0] seg_nxt;
    logic             dp_nxt;

    bin2bcd_60 u_min_bcd (
        .v     (minute),
        .tens  (min_bcd.tens),
        .ones  (min_bcd.ones),
        .valid (min_bcd.valid)
    );

    bin2bcd_60 u_sec_bcd (
        .v     (second),
        .tens  (sec_bcd.tens),
        .ones  (sec_bcd.ones),
        .valid (sec_bcd.valid)
    );

    assign tick = (prescaler == PRE_W'(REFRESH_DIV - 1));

    // Decode of the digit selected by the scan index from the frame snapshot
    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        case (digit_idx)
            2'd0: begin
                an_nxt  = AN_DIG0;
                seg_nxt = seg_code(snap_sec.ones, snap_sec.valid);
            end
            2'd1: begin
                an_nxt  = AN_DIG1;
                seg_nxt = seg_code(snap_sec.tens, snap_sec.valid);
            end
            2'd2: begin
                an_nxt  = AN_DIG2;
                seg_nxt = seg_code(snap_min.ones, snap_min.valid);
                dp_nxt  = 1'b0;
            end
            default: begin
                an_nxt  = AN_DIG3;
                seg_nxt = seg_code(snap_min.tens, snap_min.valid);
            end
        endcase
    end

    // Scan advances on tick; snapshot loads on wrap; outputs follow one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= IDX_W'(NUM_DIGITS - 1);
            tick_d    <= 1'b0;
            snap_min  <= '0;
            snap_sec  <= '0;
            an        <= AN_OFF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            tick_d    <= tick;
            if (tick) begin
                digit_idx <= digit_idx + IDX_W'(1);
                if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    snap_min <= min_bcd;
                    snap_sec <= sec_bcd;
                end
            end
            if (tick_d) begin
                an  <= an_nxt;
                seg <= seg_nxt;
                dp  <= dp_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mmss_sevenseg_driver.sv
// Scoreboard bench for mmss_sevenseg_driver: expected per-cycle display states are queued and compared each cycle.
module tb_mmss_sevenseg_driver;

    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] minute;
    logic [6:0] second;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t  q[$];
    int    checks   = 0;
    int    failures = 0;
    string cur_test = "init";
    bit    mon_en   = 1'b0;
    int    cur_m;
    int    cur_s;

    mmss_sevenseg_driver #(.REFRESH_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .minute (minute),
        .second (second),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [6:0] code(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic push_dark(input int n);
        exp_t e;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic push_frame(input int m, input int s);
        exp_t e[4];
        bit   m_ok, s_ok;
        m_ok = (m <= 59);
        s_ok = (s <= 59);
        e[0] = {4'hE, s_ok ? code(s % 10) : 7'h3F, 1'b1};
        e[1] = {4'hD, s_ok ? code(s / 10) : 7'h3F, 1'b1};
        e[2] = {4'hB, m_ok ? code(m % 10) : 7'h3F, 1'b0};
        e[3] = {4'h7, m_ok ? code(m / 10) : 7'h3F, 1'b1};
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < int'(DIV); k++) q.push_back(e[d]);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Scoreboard consumer: one expected display state per clock
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL %s underflow: an=%h seg=%h dp=%b with no expected entry", cur_test, an, seg, dp);
                end else begin
                    e = q.pop_front();
                    if ({an, seg, dp} !== e) begin
                        failures++;
                        $display("FAIL %s t=%0t: an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                                 cur_test, $time, an, seg, dp, e.an, e.seg, e.dp);
                    end
                end
            end
        end
    endtask

    // Old frame still shows after a mid-frame input change; new values appear next frame
    task automatic run_change(input int m, input int s);
        push_frame(cur_m, cur_s);
        step(1);
        minute = 7'(m);
        second = 7'(s);
        step(4 * int'(DIV) - 1);
        cur_m = m;
        cur_s = s;
        push_frame(m, s);
        step(4 * int'(DIV));
    endtask

    task automatic test_reset();
        cur_test = "reset";
        push_dark(3);
        step(3);
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_hold: an=%h seg=%h dp=%b expected an=f seg=7f dp=1", an, seg, dp);
        end
        rst = 1'b0;
        push_dark(DIV);
        step(DIV);
        checks++;
        if (an !== 4'hF) begin
            failures++;
            $display("FAIL reset_dark_after_release: an=%h expected an=f", an);
        end
        cur_m = 12;
        cur_s = 34;
        push_frame(12, 34);
        step(1);
        checks++;
        if (an !== 4'hE) begin
            failures++;
            $display("FAIL reset_first_digit: an=%h expected an=e", an);
        end
        step(4 * int'(DIV) - 1);
    endtask

    task automatic test_basic_frame();
        cur_test = "frame_12_34";
        push_frame(12, 34);
        push_frame(12, 34);
        step(8 * int'(DIV));
    endtask

    task automatic test_midframe_change();
        cur_test = "midframe_change";
        push_frame(12, 34);
        step(int'(DIV) + 1);
        checks++;
        if (an !== 4'hD) begin
            failures++;
            $display("FAIL midframe_position: an=%h expected an=d", an);
        end
        second = 7'd35;
        step(3 * int'(DIV) - 1);
        cur_s = 35;
        push_frame(12, 35);
        step(1);
        checks++;
        if ({an, seg} !== {4'hE, 7'h12}) begin
            failures++;
            $display("FAIL midframe_next_frame: an=%h seg=%h expected an=e seg=12", an, seg);
        end
        step(4 * int'(DIV) - 1);
    endtask

    task automatic test_boundaries();
        cur_test = "bound_59_59";
        run_change(59, 59);
        cur_test = "bound_00_00";
        run_change(0, 0);
        cur_test = "bound_sec_60";
        run_change(5, 60);
        cur_test = "bound_min_127";
        run_change(127, 30);
        cur_test = "bound_59_00";
        run_change(59, 0);
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        push_frame(cur_m, cur_s);
        step(2 * int'(DIV) + 1);
        checks++;
        if ({an, dp} !== {4'hB, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_position: an=%h dp=%b expected an=b dp=0", an, dp);
        end
        q.delete();
        push_dark(1);
        rst = 1'b1;
        step(1);
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_dark: an=%h seg=%h dp=%b expected an=f seg=7f dp=1", an, seg, dp);
        end
        rst = 1'b0;
        push_dark(DIV);
        push_frame(cur_m, cur_s);
        step(5 * int'(DIV));
    endtask

    task automatic test_long_run();
        cur_test = "long_run_setup";
        run_change(7, 8);
        cur_test = "long_run";
        for (int f = 0; f < 100; f++) push_frame(7, 8);
        for (int i = 0; i < 100 * 4 * int'(DIV); i++) begin
            step(1);
            checks++;
            if ($countones(~an) != 1) begin
                failures++;
                $display("FAIL long_run_one_anode cycle %0d: an=%h expected exactly one low bit", i, an);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        minute = 7'd12;
        second = 7'd34;
        cur_m  = 12;
        cur_s  = 34;
        mon_en = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic_frame();
        test_midframe_change();
        test_boundaries();
        test_reset_mid();
        test_long_run();
        mon_en = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
